// File: rtl/cmd_dispatcher.sv
// Timed command dispatcher: pops 80-bit commands, waits for their start time, issues them to a controller.
// Latency: pop -> capture -> time compare -> issue, so out_valid rises no earlier than 3 cycles after the pop.
// Backpressure: out_valid holds until out_ack or ACK_TIMEOUT cycles elapse; no new pop until back in IDLE.
module cmd_dispatcher #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] global_clock,
    input  logic [79:0] cmd_fifo_data_out,
    input  logic        cmd_fifo_empty,
    output logic        cmd_fifo_rd_en,
    output logic [7:0]  out_addr,
    output logic [7:0]  out_cmd,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        busy,
    output logic [15:0] dispatched_count,
    output logic [15:0] late_count,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_TIME = 2'd2,
        ISSUE     = 2'd3
    } state_t;

    // Last ISSUE cycle index; the command times out when the counter sits here with no ack.
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] start_q, start_d;
    logic [31:0] data_q, data_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] dispatched_q, dispatched_d;
    logic [15:0] late_q, late_d;
    logic        terr_q, terr_d;
    logic        rd_en_c;

    // Next-state, capture and counter update logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cmd_d        = cmd_q;
        start_d      = start_q;
        data_d       = data_q;
        tmo_cnt_d    = 16'd0;
        dispatched_d = dispatched_q;
        late_d       = late_q;
        terr_d       = terr_q;
        rd_en_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && !cmd_fifo_empty) begin
                    rd_en_c = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // FIFO data is valid the cycle after the pop strobe.
                addr_d  = cmd_fifo_data_out[79:72];
                cmd_d   = cmd_fifo_data_out[71:64];
                start_d = cmd_fifo_data_out[63:32];
                data_d  = cmd_fifo_data_out[31:0];
                state_d = WAIT_TIME;
            end
            WAIT_TIME: begin
                // Plain unsigned compare: a start time behind the time base issues at once.
                if (global_clock >= start_q) begin
                    state_d = ISSUE;
                    if (global_clock > start_q && late_q != 16'hFFFF) begin
                        late_d = late_q + 16'd1;
                    end
                end
            end
            ISSUE: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                // Ack wins over a timeout landing on the same cycle.
                if (out_ack) begin
                    state_d = IDLE;
                    if (dispatched_q != 16'hFFFF) begin
                        dispatched_d = dispatched_q + 16'd1;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 8'd0;
            cmd_q        <= 8'd0;
            start_q      <= 32'd0;
            data_q       <= 32'd0;
            tmo_cnt_q    <= 16'd0;
            dispatched_q <= 16'd0;
            late_q       <= 16'd0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cmd_q        <= cmd_d;
            start_q      <= start_d;
            data_q       <= data_d;
            tmo_cnt_q    <= tmo_cnt_d;
            dispatched_q <= dispatched_d;
            late_q       <= late_d;
            terr_q       <= terr_d;
        end
    end

    // The pop strobe is combinational from IDLE, so it is masked while reset is held.
    assign cmd_fifo_rd_en   = rd_en_c && !rst;
    assign out_valid        = (state_q == ISSUE);
    assign busy             = (state_q != IDLE);
    assign out_addr         = addr_q;
    assign out_cmd          = cmd_q;
    assign out_data         = data_q;
    assign dispatched_count = dispatched_q;
    assign late_count       = late_q;
    assign timeout_err      = terr_q;

endmodule
